// File: rtl/hub75_row_scanner.sv
// HUB75 panel scanner: reads one row pair per row period from a synchronous framebuffer,
// shifts it into the panel, latches it and lights it for a fixed on-time.
module hub75_row_scanner #(
  parameter int COLS         = 32,
  parameter int ROW_BITS     = 3,
  parameter int ON_CYCLES    = 64,
  parameter int BLANK_CYCLES = 2,
  localparam int COL_BITS    = $clog2(COLS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         fb_rd_en,
  output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
  input  logic [5:0]                   fb_data,
  output logic                         r1,
  output logic                         g1,
  output logic                         b1,
  output logic                         r2,
  output logic                         g2,
  output logic                         b2,
  output logic [ROW_BITS-1:0]          abc,
  output logic                         oclk,
  output logic                         lat,
  output logic                         oe,
  output logic                         frame_start
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [COL_BITS:0] COL_LAST   = (COL_BITS+1)'(COLS);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ON_LAST    = CNT_W'(ON_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_e;

  state_e                        state_q, state_d;
  logic [ROW_BITS-1:0]           row_q, row_d;
  logic [COL_BITS:0]             col_q, col_d;
  logic                          ph_q, ph_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic                          fb_rd_en_q, fb_rd_en_d;
  logic [ROW_BITS+COL_BITS-1:0]  fb_addr_q, fb_addr_d;
  logic                          rd_pend_q, rd_pend_d;
  logic [5:0]                    pix_q, pix_d;
  logic [ROW_BITS-1:0]           abc_q, abc_d;
  logic                          oclk_q, oclk_d;
  logic                          lat_q, lat_d;
  logic                          oe_q, oe_d;
  logic                          frame_start_q, frame_start_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      ph_q          <= 1'b0;
      cnt_q         <= '0;
      fb_rd_en_q    <= 1'b0;
      fb_addr_q     <= '0;
      rd_pend_q     <= 1'b0;
      pix_q         <= '0;
      abc_q         <= '0;
      oclk_q        <= 1'b0;
      lat_q         <= 1'b0;
      oe_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      ph_q          <= ph_d;
      cnt_q         <= cnt_d;
      fb_rd_en_q    <= fb_rd_en_d;
      fb_addr_q     <= fb_addr_d;
      rd_pend_q     <= rd_pend_d;
      pix_q         <= pix_d;
      abc_q         <= abc_d;
      oclk_q        <= oclk_d;
      lat_q         <= lat_d;
      oe_q          <= oe_d;
      frame_start_q <= frame_start_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SHIFT;
          col_d   = '0;
          ph_d    = 1'b0;
        end
      end
      S_SHIFT: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (col_q == COL_LAST) begin
            state_d = S_BLANK;
            col_d   = '0;
            cnt_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
        cnt_d   = '0;
      end
      S_DISPLAY: begin
        if (cnt_q == ON_LAST) begin
          // enable is only honoured at row boundaries so a row is never cut short
          row_d   = row_q + 1'b1;
          cnt_d   = '0;
          state_d = enable ? S_SHIFT : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Panel outputs are decoded from the current state and registered, so they trail it by one cycle.
  always_comb begin
    fb_rd_en_d    = 1'b0;
    fb_addr_d     = fb_addr_q;
    oclk_d        = 1'b0;
    lat_d         = 1'b0;
    oe_d          = 1'b1;
    abc_d         = abc_q;
    rd_pend_d     = fb_rd_en_q;
    pix_d         = rd_pend_q ? fb_data : pix_q;
    case (state_q)
      S_SHIFT: begin
        if (!ph_q && col_q != COL_LAST) begin
          fb_rd_en_d = 1'b1;
          fb_addr_d  = {row_q, col_q[COL_BITS-1:0]};
        end
        if (ph_q && col_q != '0) oclk_d = 1'b1;
      end
      S_BLANK:   abc_d = row_q;
      S_LATCH:   lat_d = 1'b1;
      S_DISPLAY: oe_d  = 1'b0;
      default:   ;
    endcase
    frame_start_d = (state_d == S_SHIFT) && (state_q != S_SHIFT) && (row_d == '0);
  end

  assign fb_rd_en                 = fb_rd_en_q;
  assign fb_addr                  = fb_addr_q;
  assign {r1, g1, b1, r2, g2, b2} = pix_q;
  assign abc                      = abc_q;
  assign oclk                     = oclk_q;
  assign lat                      = lat_q;
  assign oe                       = oe_q;
  assign frame_start              = frame_start_q;

endmodule

// File: tb/tb_hub75_row_scanner.sv
// Self-checking bench for hub75_row_scanner: a timeline model of each row period is compared
// cycle by cycle against the panel pins, using a synchronous RAM model as the framebuffer.
module tb_hub75_row_scanner;

  localparam int COLS         = 32;
  localparam int ROW_BITS     = 3;
  localparam int ON_CYCLES    = 64;
  localparam int BLANK_CYCLES = 2;
  localparam int ROWS         = 1 << ROW_BITS;
  localparam int BLANK_IDX    = 2 * (COLS + 1);
  localparam int LAT_IDX      = BLANK_IDX + BLANK_CYCLES;
  localparam int DISP_IDX     = LAT_IDX + 1;
  localparam int ROW_PERIOD   = DISP_IDX + ON_CYCLES;
  localparam int FRAME_PERIOD = ROWS * ROW_PERIOD;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fb_rd_en;
  logic [7:0] fb_addr;
  logic [5:0] fb_data = '0;
  logic       r1, g1, b1, r2, g2, b2;
  logic [2:0] abc;
  logic       oclk, lat, oe, frame_start;
  logic [5:0] pins;
  logic [5:0] mem [0:255];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_fs  = 0;
  bit fs_seen  = 0;

  hub75_row_scanner #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .ON_CYCLES(ON_CYCLES), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .abc(abc), .oclk(oclk), .lat(lat), .oe(oe), .frame_start(frame_start)
  );

  assign pins = {r1, g1, b1, r2, g2, b2};

  always #5 clk = ~clk;

  // Framebuffer: data is valid the cycle after the read strobe.
  always @(posedge clk) if (fb_rd_en === 1'b1) fb_data <= mem[fb_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (frame_start === 1'b1) begin
      if (fs_seen) check("frame_period", cyc - last_fs, FRAME_PERIOD);
      fs_seen = 1;
      last_fs = cyc;
    end
  endtask

  task automatic check_blanked(input string tag, input bit fs_exp);
    check({tag, "_oe"}, oe, 1'b1);
    check({tag, "_rd_en"}, fb_rd_en, 1'b0);
    check({tag, "_lat"}, lat, 1'b0);
    check({tag, "_oclk"}, oclk, 1'b0);
    check({tag, "_fstart"}, frame_start, fs_exp);
  endtask

  // Cycle i=0 is the first visible read strobe of row r; the row spans ROW_PERIOD cycles.
  task automatic run_row(input int r, input bit next_shift, input int drop_at, input int stop_at);
    int  rd_cnt = 0;
    int  ck_cnt = 0;
    int  k;
    bit  rd_exp, ck_exp;
    for (int i = 0; i < stop_at; i++) begin
      tick();
      k      = i / 2;
      rd_exp = (i < 2 * COLS) && (i % 2 == 0);
      ck_exp = (i % 2 == 1) && (k >= 1) && (k <= COLS);
      check("rd_en", fb_rd_en, rd_exp);
      if (rd_exp) check("addr", fb_addr, r * COLS + k);
      check("oclk", oclk, ck_exp);
      if (ck_exp) check("pix_at_oclk", pins, mem[r * COLS + k - 1]);
      if (i >= 2 * COLS) check("pix_hold", pins, mem[r * COLS + COLS - 1]);
      check("lat", lat, i == LAT_IDX);
      check("oe", oe, i < DISP_IDX);
      if (i >= BLANK_IDX) check("abc", abc, r);
      check("fstart", frame_start,
            (i == ROW_PERIOD - 1) && next_shift && ((r + 1) % ROWS == 0));
      rd_cnt += int'(fb_rd_en);
      ck_cnt += int'(oclk);
      if (i == drop_at) enable = 1'b0;
    end
    if (stop_at == ROW_PERIOD) begin
      check("rd_count", rd_cnt, COLS);
      check("oclk_count", ck_cnt, COLS);
    end
  endtask

  initial begin
    int drop_at, idle_n, stop_at;
    for (int a = 0; a < 256; a++) mem[a] = 6'(a);
    reset  = 1'b0;
    enable = 1'b1;

    repeat (3) begin
      tick();
      check_blanked("reset", 1'b0);
      check("reset_abc", abc, 0);
    end

    reset = 1'b1;
    tick();
    check("rel_fstart", frame_start, 1'b1);
    check("rel_rd_en", fb_rd_en, 1'b0);

    for (int r = 0; r < ROWS; r++) run_row(r, 1'b1, -1, ROW_PERIOD);

    for (int a = 0; a < 256; a++) mem[a] = 6'($urandom);
    drop_at = $urandom_range(0, 2 * COLS + 1);
    for (int r = 0; r < 3; r++) run_row(r, 1'b1, -1, ROW_PERIOD);
    run_row(3, 1'b0, drop_at, ROW_PERIOD);

    idle_n = $urandom_range(3, 10);
    repeat (idle_n) begin
      tick();
      check_blanked("idle", 1'b0);
    end
    enable = 1'b1;
    tick();
    check_blanked("resume", 1'b0);
    run_row(4, 1'b1, -1, ROW_PERIOD);

    stop_at = $urandom_range(DISP_IDX + 1, ROW_PERIOD - 2);
    run_row(5, 1'b1, -1, stop_at);
    check("pre_reset_oe", oe, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_blanked("async_reset", 1'b0);
    check("async_reset_abc", abc, 0);
    fs_seen = 0;
    repeat (3) begin
      tick();
      check_blanked("reset_hold", 1'b0);
    end
    reset = 1'b1;
    tick();
    check("rerel_fstart", frame_start, 1'b1);
    check("rerel_rd_en", fb_rd_en, 1'b0);
    run_row(0, 1'b1, -1, ROW_PERIOD);
    run_row(1, 1'b1, -1, ROW_PERIOD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
